// File: rtl/slew_rate_detector_if.sv
// ----------------------------------------------------------------------------
// slew_rate_detector_if
//   Sample-path bundle for slew_rate_detector.
//   master : drives the sample strobe and sample, observes the measurements.
//   slave  : the detector itself.
// Signals
//   audio_clk_en  1   one-clk sample strobe
//   in            16  signed input sample
//   delta         17  signed in - previous in
//   slew_active   1   detector is not idle
//   slew_dir      1   1 = rising, 0 = falling (0 when idle)
//   peak_delta    16  max |delta| of the current/last event
//   event_count   16  saturating count of direction entries
// ----------------------------------------------------------------------------
interface slew_rate_detector_if;
   logic               audio_clk_en;
   logic signed [15:0] in;
   logic signed [16:0] delta;
   logic               slew_active;
   logic               slew_dir;
   logic [15:0]        peak_delta;
   logic [15:0]        event_count;

   modport master (
      output audio_clk_en, in,
      input  delta, slew_active, slew_dir, peak_delta, event_count
   );

   modport slave (
      input  audio_clk_en, in,
      output delta, slew_active, slew_dir, peak_delta, event_count
   );
endinterface

// File: rtl/slew_rate_detector.sv
// ----------------------------------------------------------------------------
// slew_rate_detector
//   Measures the per-sample rate of change of a signed 16-bit audio node and
//   flags slewing events: direction, peak step and a saturating event count.
// Ports
//   clk    system clock
//   I_RST  synchronous reset, active-high (wins over the sample strobe)
//   bus    slew_rate_detector_if.slave (strobe, sample, measurement outputs)
// All outputs are registered and change only on a strobed clock edge.
// ----------------------------------------------------------------------------
module slew_rate_detector #(
   parameter int VCC            = 12,
   parameter int SAMPLE_RATE    = 48000,
   parameter int THRESHOLD_RATE = 950,
   parameter int DEBOUNCE       = 2,
   parameter int HOLD_SAMPLES   = 480
) (
   input logic                 clk,
   input logic                 I_RST,
   slew_rate_detector_if.slave bus
);

   // Threshold in LSB per sample: 1 V = 2^14/VCC LSB.
   localparam int          THRESH   = (THRESHOLD_RATE << 14) / VCC / SAMPLE_RATE;
   localparam logic [16:0] THRESH_V = 17'(THRESH);

   localparam int DEB_W  = $clog2(DEBOUNCE + 1);
   localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RISING  = 2'd1;
   localparam logic [1:0] ST_FALLING = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   logic [1:0]         state_reg,       state_next;
   logic signed [15:0] prev_in_reg,     prev_in_next;
   logic signed [16:0] delta_reg,       delta_next;
   logic               slew_active_reg, slew_active_next;
   logic               slew_dir_reg,    slew_dir_next;
   logic [15:0]        peak_reg,        peak_next;
   logic [15:0]        event_reg,       event_next;
   logic [DEB_W-1:0]   dbc_cnt_reg,     dbc_cnt_next;
   logic               dbc_neg_reg,     dbc_neg_next;
   logic [HOLD_W-1:0]  hold_reg,        hold_next;

   // Difference of the current and previous sample, evaluated every clk;
   // only used when the strobe is high.
   logic signed [16:0] diff;
   logic [16:0]        diff_abs17;
   logic [15:0]        diff_abs;
   logic               diff_neg;
   logic               over;
   logic [15:0]        peak_max;
   logic [DEB_W-1:0]   dbc_cand;
   logic               enter;

   always_comb begin
      diff       = {bus.in[15], bus.in} - {prev_in_reg[15], prev_in_reg};
      diff_neg   = diff[16];
      diff_abs17 = diff_neg ? (17'd0 - diff) : diff;
      // Magnitude never exceeds 65535, so the top bit is always clear.
      diff_abs   = diff_abs17[15:0];
      over       = diff_abs17 > THRESH_V;
      peak_max   = (diff_abs > peak_reg) ? diff_abs : peak_reg;
   end

   always_comb begin
      state_next       = state_reg;
      prev_in_next     = prev_in_reg;
      delta_next       = delta_reg;
      slew_active_next = slew_active_reg;
      slew_dir_next    = slew_dir_reg;
      peak_next        = peak_reg;
      event_next       = event_reg;
      dbc_cnt_next     = dbc_cnt_reg;
      dbc_neg_next     = dbc_neg_reg;
      hold_next        = hold_reg;
      dbc_cand         = '0;
      enter            = 1'b0;

      if (bus.audio_clk_en) begin
         prev_in_next = bus.in;
         delta_next   = diff;

         case (state_reg)
            ST_IDLE: begin
               // A non-zero count means the previous sample was over, with
               // sign dbc_neg_reg.
               if (over && (dbc_cnt_reg != '0) && (dbc_neg_reg == diff_neg))
                  dbc_cand = dbc_cnt_reg + 1'b1;
               else
                  dbc_cand = over ? DEB_W'(1) : '0;
               dbc_neg_next = diff_neg;
               if (dbc_cand == DEB_W'(DEBOUNCE)) begin
                  state_next   = diff_neg ? ST_FALLING : ST_RISING;
                  peak_next    = diff_abs;
                  dbc_cnt_next = '0;
                  enter        = 1'b1;
               end else begin
                  dbc_cnt_next = dbc_cand;
               end
            end
            ST_RISING, ST_FALLING: begin
               peak_next = peak_max;
               if (over) begin
                  // Reversal switches direction immediately, no debounce.
                  if (diff_neg && (state_reg == ST_RISING)) begin
                     state_next = ST_FALLING;
                     enter      = 1'b1;
                  end else if (!diff_neg && (state_reg == ST_FALLING)) begin
                     state_next = ST_RISING;
                     enter      = 1'b1;
                  end
               end else begin
                  state_next = ST_HOLD;
                  hold_next  = HOLD_W'(HOLD_SAMPLES);
               end
            end
            default: begin // ST_HOLD
               peak_next = peak_max;
               if (over) begin
                  state_next = diff_neg ? ST_FALLING : ST_RISING;
                  hold_next  = '0;
                  enter      = 1'b1;
               end else begin
                  hold_next = hold_reg - 1'b1;
                  if (hold_reg == HOLD_W'(1))
                     state_next = ST_IDLE;
               end
            end
         endcase

         if (enter && (event_reg != 16'hFFFF))
            event_next = event_reg + 16'd1;

         slew_active_next = (state_next != ST_IDLE);
         case (state_next)
            ST_RISING:  slew_dir_next = 1'b1;
            ST_FALLING: slew_dir_next = 1'b0;
            ST_HOLD:    slew_dir_next = slew_dir_reg;
            default:    slew_dir_next = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (I_RST) begin
         state_reg       <= ST_IDLE;
         prev_in_reg     <= '0;
         delta_reg       <= '0;
         slew_active_reg <= 1'b0;
         slew_dir_reg    <= 1'b0;
         peak_reg        <= '0;
         event_reg       <= '0;
         dbc_cnt_reg     <= '0;
         dbc_neg_reg     <= 1'b0;
         hold_reg        <= '0;
      end else begin
         state_reg       <= state_next;
         prev_in_reg     <= prev_in_next;
         delta_reg       <= delta_next;
         slew_active_reg <= slew_active_next;
         slew_dir_reg    <= slew_dir_next;
         peak_reg        <= peak_next;
         event_reg       <= event_next;
         dbc_cnt_reg     <= dbc_cnt_next;
         dbc_neg_reg     <= dbc_neg_next;
         hold_reg        <= hold_next;
      end
   end

   assign bus.delta       = delta_reg;
   assign bus.slew_active = slew_active_reg;
   assign bus.slew_dir    = slew_dir_reg;
   assign bus.peak_delta  = peak_reg;
   assign bus.event_count = event_reg;

endmodule

// File: tb/tb_slew_rate_detector.sv
module tb_slew_rate_detector;

   logic clk = 1'b0;
   logic I_RST;
   always #5 clk = ~clk;

   slew_rate_detector_if bus ();

   slew_rate_detector #(
      .DEBOUNCE     (2),
      .HOLD_SAMPLES (4)
   ) dut (
      .clk   (clk),
      .I_RST (I_RST),
      .bus   (bus)
   );

   typedef struct {
      logic        rst;
      logic        en;
      int          din;
      int          exp_delta;
      logic        exp_act;
      logic        exp_dir;
      int          exp_peak;
      int          exp_ev;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic add(input logic rst, input logic en, input int din, input int d,
                      input logic act, input logic dir, input int pk, input int ev);
      vec_t v;
      v.rst = rst; v.en = en; v.din = din; v.exp_delta = d;
      v.exp_act = act; v.exp_dir = dir; v.exp_peak = pk; v.exp_ev = ev;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock of stimulus, then check all outputs just after the edge.
   task automatic apply(input string tag, input logic rst, input logic en, input int din,
                        input int d, input logic act, input logic dir, input int pk, input int ev);
      @(negedge clk);
      I_RST            = rst;
      bus.audio_clk_en = en;
      bus.in           = 16'(din);
      @(posedge clk);
      #1;
      $display("%s: rst=%0b en=%0b in=%0d -> delta=%0d act=%0b dir=%0b peak=%0d ev=%0d",
               tag, rst, en, $signed(16'(din)), bus.delta, bus.slew_active,
               bus.slew_dir, bus.peak_delta, bus.event_count);
      chk({tag, " delta"},  int'(bus.delta), d);
      chk({tag, " active"}, int'(bus.slew_active), int'(act));
      chk({tag, " dir"},    int'(bus.slew_dir), int'(dir));
      chk({tag, " peak"},   int'(bus.peak_delta), pk);
      chk({tag, " events"}, int'(bus.event_count), ev);
   endtask

   initial begin
      I_RST            = 1'b0;
      bus.audio_clk_en = 1'b0;
      bus.in           = '0;

      // Reset beats a simultaneous strobe.
      add(1, 1, 1000,   0, 0, 0,   0, 0);
      // Slow ramp and threshold boundary (27 is not over, 28 is).
      add(0, 1,   20,  20, 0, 0,   0, 0);
      add(0, 1,   40,  20, 0, 0,   0, 0);
      add(0, 1,   60,  20, 0, 0,   0, 0);
      add(0, 1,   87,  27, 0, 0,   0, 0);
      add(0, 1,  114,  27, 0, 0,   0, 0);
      add(0, 1,  142,  28, 0, 0,   0, 0);
      add(0, 1,  170,  28, 1, 1,  28, 1);
      // Reset in the middle of an event.
      add(1, 1,    5,   0, 0, 0,   0, 0);
      // +100 ramp, debounce of two.
      add(0, 1,  100, 100, 0, 0,   0, 0);
      add(0, 1,  200, 100, 1, 1, 100, 1);
      // Quiet: HOLD for four strobes, IDLE on the fifth.
      add(0, 1,  200,   0, 1, 1, 100, 1);
      add(0, 1,  200,   0, 1, 1, 100, 1);
      add(0, 1,  200,   0, 1, 1, 100, 1);
      add(0, 1,  200,   0, 1, 1, 100, 1);
      add(0, 1,  200,   0, 0, 0, 100, 1);
      // Reversal straight to FALLING, then HOLD re-entry.
      add(1, 1,    0,   0, 0, 0,   0, 0);
      add(0, 1,  100, 100, 0, 0,   0, 0);
      add(0, 1,  200, 100, 1, 1, 100, 1);
      add(0, 1,    0,-200, 1, 0, 200, 2);
      add(0, 1,    0,   0, 1, 0, 200, 2);
      add(0, 1,   50,  50, 1, 1, 200, 3);
      add(0, 1,   50,   0, 1, 1, 200, 3);
      add(0, 0,  999,   0, 1, 1, 200, 3);
      // Opposite-sign over samples reload the debounce count.
      add(1, 1,    0,   0, 0, 0,   0, 0);
      add(0, 1,  100, 100, 0, 0,   0, 0);
      add(0, 1,    0,-100, 0, 0,   0, 0);
      add(0, 1, -100,-100, 1, 0, 100, 1);

      foreach (tbl[i])
         apply($sformatf("vec %0d", i), tbl[i].rst, tbl[i].en, tbl[i].din,
               tbl[i].exp_delta, tbl[i].exp_act, tbl[i].exp_dir,
               tbl[i].exp_peak, tbl[i].exp_ev);

      // Full-scale swing without wrap.
      apply("fs rst",  1, 1,      0,      0, 0, 0,     0, 0);
      apply("fs a",    0, 1,  16000,  16000, 0, 0,     0, 0);
      apply("fs b",    0, 1,  32767,  16767, 1, 1, 16767, 1);
      apply("fs c",    0, 1, -32768, -65535, 1, 0, 65535, 2);

      // No strobe for ten clocks while the input toggles: everything holds.
      for (int k = 0; k < 10; k++)
         apply($sformatf("gap %0d", k), 0, 0, (k % 2 == 0) ? 1234 : -4321,
               -65535, 1, 0, 65535, 2);

      // prev_in survived the gap: same sample gives zero delta, enters HOLD.
      apply("post gap", 0, 1, -32768, 0, 1, 0, 65535, 2);

      @(negedge clk);
      bus.audio_clk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
